uart_rx: RTL and testbench

// - Receive side of the UART link: oversamples the serial line, detects the start bit,

---
 rtl/uart_rx_if.sv | 42 ++++
 rtl/uart_rx.sv | 211 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if
// Bundles the serial line, the frame-format configuration and the receive
// results of the UART receiver into one interface.
//
// Signals:
//   RX_IN       serial line, idle high, asynchronous to the receiver clock
//   Prescale    oversampling ratio (8, 16 or 32)
//   PAR_EN      1 = a parity bit follows the data bits
//   PAR_TYP     0 = even parity, 1 = odd parity
//   P_DATA      payload of the last good frame
//   data_valid  1-cycle pulse: new good frame on P_DATA
//   par_err     1-cycle pulse: parity mismatch
//   stp_err     1-cycle pulse: stop bit sampled low
//
// Modports:
//   master  line/configuration side (drives RX_IN and the frame format)
//   slave   the receiver itself (drives the results)
// ---------------------------------------------------------------------------
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
);
    logic                  RX_IN;
    logic [PRESC_W-1:0]    Prescale;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;

    modport master (
        output RX_IN, Prescale, PAR_EN, PAR_TYP,
        input  P_DATA, data_valid, par_err, stp_err
    );

    modport slave (
        input  RX_IN, Prescale, PAR_EN, PAR_TYP,
        output P_DATA, data_valid, par_err, stp_err
    );
endinterface

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// Receive side of the UART link. Oversamples the serial line, detects the
// start bit, shifts in DATA_WIDTH bits LSB-first, checks the optional parity
// bit and the stop bit, and reports the result one cycle after the stop bit
// ends.
//
// Ports:
//   CLK   oversampling clock
//   RST   synchronous, active-high reset
//   bus   uart_rx_if.slave: RX_IN, Prescale, PAR_EN, PAR_TYP in;
//         P_DATA, data_valid, par_err, stp_err out
//
// Build option:
//   UART_RX_MAJORITY_VOTE_EN  when defined, each bit is the majority of three
//                             samples around mid-bit instead of a single
//                             mid-bit sample.
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic     CLK,
    input  logic     RST,
    uart_rx_if.slave bus
);
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state_q,     state_d;
    logic                  sync1_q,     rxS_q;
    logic [PRESC_W-1:0]    edgeCnt_q,   edgeCnt_d;
    logic [PRESC_W-1:0]    prescale_q,  prescale_d;
    logic [BIT_W-1:0]      bitCnt_q,    bitCnt_d;
    logic [DATA_WIDTH-1:0] shift_q,     shift_d;
    logic                  parEn_q,     parEn_d;
    logic                  parTyp_q,    parTyp_d;
    logic                  parFlag_q,   parFlag_d;
    logic                  stpFlag_q,   stpFlag_d;
    logic [DATA_WIDTH-1:0] pData_q,     pData_d;
    logic                  dataValid_q, dataValid_d;
    logic                  parErr_q,    parErr_d;
    logic                  stpErr_q,    stpErr_d;

    logic [PRESC_W-1:0]    halfEdge;
    logic                  lastEdge;
    logic                  sampleNow;
    logic                  sampleBit;

    assign halfEdge = prescale_q >> 1;
    assign lastEdge = (edgeCnt_q == prescale_q - PRESC_W'(1));

`ifdef UART_RX_MAJORITY_VOTE_EN
    // The two early samples are kept; the third is the live bit at the
    // decision edge, so the decision lands one edge after mid-bit.
    logic [1:0] vote_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            vote_q <= 2'b11;
        end else begin
            if (edgeCnt_q == halfEdge - PRESC_W'(1)) vote_q[0] <= rxS_q;
            if (edgeCnt_q == halfEdge)               vote_q[1] <= rxS_q;
        end
    end

    assign sampleNow = (state_q != IDLE) && (edgeCnt_q == halfEdge + PRESC_W'(1));
    assign sampleBit = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxS_q) | (vote_q[1] & rxS_q);
`else
    assign sampleNow = (state_q != IDLE) && (edgeCnt_q == halfEdge);
    assign sampleBit = rxS_q;
`endif

    // The synchronizer resets high so a reset never looks like a start bit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b1;
            rxS_q       <= 1'b1;
            edgeCnt_q   <= '0;
            prescale_q  <= '0;
            bitCnt_q    <= '0;
            shift_q     <= '0;
            parEn_q     <= 1'b0;
            parTyp_q    <= 1'b0;
            parFlag_q   <= 1'b0;
            stpFlag_q   <= 1'b0;
            pData_q     <= '0;
            dataValid_q <= 1'b0;
            parErr_q    <= 1'b0;
            stpErr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= bus.RX_IN;
            rxS_q       <= sync1_q;
            edgeCnt_q   <= edgeCnt_d;
            prescale_q  <= prescale_d;
            bitCnt_q    <= bitCnt_d;
            shift_q     <= shift_d;
            parEn_q     <= parEn_d;
            parTyp_q    <= parTyp_d;
            parFlag_q   <= parFlag_d;
            stpFlag_q   <= stpFlag_d;
            pData_q     <= pData_d;
            dataValid_q <= dataValid_d;
            parErr_q    <= parErr_d;
            stpErr_q    <= stpErr_d;
        end
    end

    // The cycle IDLE first sees a low line is already edge 0 of the start
    // bit, so the counter enters START at 1. Every later bit restarts at 0.
    always_comb begin
        state_d     = state_q;
        edgeCnt_d   = edgeCnt_q + PRESC_W'(1);
        prescale_d  = prescale_q;
        bitCnt_d    = bitCnt_q;
        shift_d     = shift_q;
        parEn_d     = parEn_q;
        parTyp_d    = parTyp_q;
        parFlag_d   = parFlag_q;
        stpFlag_d   = stpFlag_q;
        pData_d     = pData_q;
        dataValid_d = 1'b0;
        parErr_d    = 1'b0;
        stpErr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                edgeCnt_d = '0;
                if (!rxS_q) begin
                    state_d    = START;
                    edgeCnt_d  = PRESC_W'(1);
                    prescale_d = bus.Prescale;
                    parEn_d    = bus.PAR_EN;
                    parTyp_d   = bus.PAR_TYP;
                    parFlag_d  = 1'b0;
                    stpFlag_d  = 1'b0;
                    bitCnt_d   = '0;
                end
            end
            START: begin
                if (sampleNow && sampleBit) begin
                    state_d   = IDLE;
                    edgeCnt_d = '0;
                end else if (lastEdge) begin
                    state_d   = DATA;
                    edgeCnt_d = '0;
                end
            end
            DATA: begin
                if (sampleNow) begin
                    shift_d                 = shift_q >> 1;
                    shift_d[DATA_WIDTH-1]   = sampleBit;
                end
                if (lastEdge) begin
                    edgeCnt_d = '0;
                    if (bitCnt_q == BIT_W'(DATA_WIDTH - 1)) begin
                        bitCnt_d = '0;
                        state_d  = parEn_q ? PARITY : STOP;
                    end else begin
                        bitCnt_d = bitCnt_q + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (sampleNow) begin
                    parFlag_d = sampleBit ^ (^shift_q) ^ parTyp_q;
                end
                if (lastEdge) begin
                    state_d   = STOP;
                    edgeCnt_d = '0;
                end
            end
            STOP: begin
                if (sampleNow) begin
                    stpFlag_d = ~sampleBit;
                end
                // The stop sample is always well before the last edge, so the
                // held flags are final here.
                if (lastEdge) begin
                    state_d   = IDLE;
                    edgeCnt_d = '0;
                    if (!parFlag_q && !stpFlag_q) begin
                        dataValid_d = 1'b1;
                        pData_d     = shift_q;
                    end else begin
                        parErr_d = parFlag_q;
                        stpErr_d = stpFlag_q;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                edgeCnt_d = '0;
            end
        endcase
    end

    assign bus.P_DATA     = pData_q;
    assign bus.data_valid = dataValid_q;
    assign bus.par_err    = parErr_q;
    assign bus.stp_err    = stpErr_q;
endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Drives directed UART frames into uart_rx. For every frame sent, the bench
// works out from the frame contents when the result must appear and what it
// must be, queues that, and a single negedge process checks all outputs on
// every cycle against the queued model. A few literal expectations pin the
// latency and payloads of the reference frames.
// ---------------------------------------------------------------------------
module tb_uart_rx;
    logic clk;
    logic rst;

    uart_rx_if #(.DATA_WIDTH(8), .PRESC_W(6)) bus ();

    uart_rx #(.DATA_WIDTH(8), .PRESC_W(6)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    typedef struct {
        int         cyc;
        bit         valid;
        bit         perr;
        bit         serr;
        logic [7:0] data;
    } exp_t;

    exp_t       expQ[$];
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic       rstAtEdge = 1'b0;
    bit         checkEn   = 1'b0;
    logic [7:0] modelData = 8'h00;
    int         validCount  = 0;
    int         parErrCount = 0;
    int         stpErrCount = 0;
    int         lastValidCycle = -1;
    int         lastDrop = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle index counts posedges; the interval after posedge n is cycle n.
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        rstAtEdge <= rst;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Per-cycle compare against the frame-level model.
    always @(negedge clk) begin
        logic [10:0] expV;
        logic [10:0] actV;
        exp_t        e;
        if (rstAtEdge) checkEn = 1'b1;
        if (checkEn) begin
            expV = {3'b000, modelData};
            if (rstAtEdge) begin
                expQ.delete();
                modelData = 8'h00;
                expV = 11'h000;
            end else if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
                e = expQ.pop_front();
                if (e.valid) modelData = e.data;
                expV = {e.valid, e.perr, e.serr, modelData};
            end
            actV = {bus.data_valid, bus.par_err, bus.stp_err, bus.P_DATA};
            checkOutput($sformatf("cycle%0d {valid,perr,serr,data}", cyc), int'(actV), int'(expV));
            if (bus.data_valid === 1'b1) begin
                validCount++;
                lastValidCycle = cyc;
            end
            if (bus.par_err === 1'b1) parErrCount++;
            if (bus.stp_err === 1'b1) stpErrCount++;
        end
    end

    task automatic idle(input int n);
        bus.RX_IN = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic driveBit(input logic b, input int presc);
        bus.RX_IN = b;
        repeat (presc) @(posedge clk);
        #1;
    endtask

    // The result is due two synchronizer cycles after the line drops plus
    // one Prescale period per frame bit (start, data, optional parity, stop).
    task automatic applyStimulus(input logic [7:0] data, input int presc, input bit parEn,
                                 input bit parTyp, input bit parBit, input bit stopBit);
        exp_t e;
        int   ones;
        int   nBits;
        bus.Prescale = 6'(presc);
        bus.PAR_EN   = parEn;
        bus.PAR_TYP  = parTyp;
        ones  = $countones(data) + ((parEn && parBit) ? 1 : 0);
        nBits = 10 + (parEn ? 1 : 0);
        e.cyc   = cyc + 2 + nBits * presc;
        e.perr  = parEn && ((ones % 2) != (parTyp ? 1 : 0));
        e.serr  = !stopBit;
        e.valid = !e.perr && !e.serr;
        e.data  = data;
        expQ.push_back(e);
        lastDrop = cyc;
        driveBit(1'b0, presc);
        for (int i = 0; i < 8; i++) driveBit(data[i], presc);
        if (parEn) driveBit(parBit, presc);
        driveBit(stopBit, presc);
    endtask

    initial begin
        int vc;
        int pc;
        int sc;
        rst          = 1'b1;
        bus.RX_IN    = 1'b1;
        bus.Prescale = 6'd8;
        bus.PAR_EN   = 1'b0;
        bus.PAR_TYP  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset P_DATA", int'(bus.P_DATA), 0);
        checkOutput("reset pulses", int'({bus.data_valid, bus.par_err, bus.stp_err}), 0);
        rst = 1'b0;
        idle(5);

        $display("[TB] frame 0xA5, Prescale 8, no parity");
        applyStimulus(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(6);
        checkOutput("A5 latency", lastValidCycle - (lastDrop + 2), 80);
        checkOutput("A5 P_DATA", int'(bus.P_DATA), 'hA5);

        $display("[TB] frame 0x3C, Prescale 16, even parity, good");
        applyStimulus(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(6);
        checkOutput("3C latency", lastValidCycle - (lastDrop + 2), 176);
        checkOutput("3C P_DATA", int'(bus.P_DATA), 'h3C);

        $display("[TB] frame 0x3C with wrong parity bit");
        vc = validCount;
        pc = parErrCount;
        applyStimulus(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(6);
        checkOutput("bad parity par_err count", parErrCount - pc, 1);
        checkOutput("bad parity no valid", validCount - vc, 0);
        checkOutput("bad parity P_DATA kept", int'(bus.P_DATA), 'h3C);

        $display("[TB] frame 0x55 with stop bit 0, then 0x0F");
        sc = stpErrCount;
        applyStimulus(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(6);
        checkOutput("bad stop stp_err count", stpErrCount - sc, 1);
        applyStimulus(8'h0F, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(6);
        checkOutput("0F after stop error", int'(bus.P_DATA), 'h0F);

        $display("[TB] 2-cycle glitch on idle line, Prescale 16");
        vc = validCount;
        pc = parErrCount;
        sc = stpErrCount;
        bus.Prescale = 6'd16;
        bus.RX_IN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idle(60);
        checkOutput("glitch pulses", (validCount - vc) + (parErrCount - pc) + (stpErrCount - sc), 0);

        $display("[TB] line held low for two frame times");
        sc = stpErrCount;
        applyStimulus(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(6);
        checkOutput("break stp_err count", stpErrCount - sc, 2);

        $display("[TB] back-to-back 0x01, 0xFE, odd parity");
        vc = validCount;
        applyStimulus(8'h01, 8, 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(8'hFE, 8, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(6);
        checkOutput("back-to-back valid count", validCount - vc, 2);
        checkOutput("back-to-back P_DATA", int'(bus.P_DATA), 'hFE);

        $display("[TB] reset in the middle of a frame");
        vc = validCount;
        bus.Prescale = 6'd8;
        bus.PAR_EN   = 1'b0;
        driveBit(1'b0, 8);
        driveBit(1'b0, 8);
        driveBit(1'b1, 8);
        bus.RX_IN = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(120);
        checkOutput("mid-frame reset no valid", validCount - vc, 0);
        checkOutput("mid-frame reset P_DATA", int'(bus.P_DATA), 0);

        checkOutput("expected results outstanding", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
